tick_gen: RTL and testbench

Parametrised multi-channel tick generator for the LCD lab design. From the single board clock it produces `NUM_CH` independent one-cycle enable pulses. Each channel has a divisor that can be reprogrammed at run time; new divisors are applied without glitches. Channels can be enabled individually, and all channels can be phase-aligned with one synchronous restart. Downstream timers, scroll logic and LCD command sequencers consume the `tick` outputs as clock enables.

---
 rtl/tick_gen_pkg.sv | 13 +
 rtl/tick_gen_if.sv | 32 +++
 rtl/tick_gen_ch.sv | 81 ++++++++
 rtl/tick_gen.sv | 56 +++++
 tb/tb_tick_gen.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tick_gen_pkg.sv
// Shared constants, divisor type and the divisor clamp helper for the tick generator.
package tick_gen_pkg;

    localparam int CNT_W_DEFAULT = 26;

    typedef logic [CNT_W_DEFAULT-1:0] div_t;

    // A divisor of 0 could never wrap, so it is treated as 1 (tick every active cycle).
    function automatic logic [63:0] clamp_div(input logic [63:0] d);
        return (d == 64'd0) ? 64'd1 : d;
    endfunction

endpackage

// File: rtl/tick_gen_if.sv
// Control, configuration and tick bundle between a tick_gen and its user.
interface tick_gen_if
    import tick_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEFAULT
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              en;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] square;
    logic [NUM_CH-1:0] div_pending;

    modport master (
        output en, ch_en, sync, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, tick, square, div_pending
    );

    modport slave (
        input  en, ch_en, sync, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, tick, square, div_pending
    );

endinterface

// File: rtl/tick_gen_ch.sv
// One tick channel: counter, active/shadow divisor, pending flag, tick and square.
// The square toggle flop exists only when TICK_GEN_SQUARE_EN is defined.
module tick_gen_ch
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W     = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] RESET_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    output logic             tick,
    output logic             square,
    output logic             pend
);

    localparam logic [CNT_W-1:0] RESET_DIV_C = CNT_W'(clamp_div(64'(RESET_DIV)));

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] wr_div_c;
    logic             wrap;
    logic             apply;

    assign wr_div_c = CNT_W'(clamp_div(64'(wr_div)));
    assign wrap     = active && (cnt == div - CNT_W'(1));
    // A waiting divisor lands on a wrap or whenever the channel is idle, so it never cuts a period short.
    assign apply    = pend && (wrap || !active);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            div    <= RESET_DIV_C;
            shadow <= RESET_DIV_C;
            pend   <= 1'b0;
            tick   <= 1'b0;
        end else if (sync) begin
            cnt    <= '0;
            tick   <= 1'b0;
            pend   <= 1'b0;
            div    <= wr ? wr_div_c : shadow;
            shadow <= wr ? wr_div_c : shadow;
        end else begin
            if (wrap) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else if (active) begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end else begin
                tick <= 1'b0;
            end
            if (apply) begin
                div <= shadow;
            end
            if (wr) begin
                shadow <= wr_div_c;
                pend   <= 1'b1;
            end else if (apply) begin
                pend <= 1'b0;
            end
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            square <= 1'b0;
        end else if (wrap) begin
            square <= ~square;
        end
    end
`else
    assign square = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: NUM_CH tick_gen_ch instances plus divisor-write decode.
// Square outputs are built only with TICK_GEN_SQUARE_EN defined.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int                      INPUT_FREQ  = 50_000_000,
    parameter int                      NUM_CH      = 4,
    parameter int                      CNT_W       = CNT_W_DEFAULT,
    parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV = {NUM_CH{CNT_W'(INPUT_FREQ / 1000)}}
) (
    input  logic       clk,
    input  logic       rst,
    tick_gen_if.slave  bus
);

    logic              cfg_ready_q;
    logic [NUM_CH-1:0] tick_v;
    logic [NUM_CH-1:0] square_v;
    logic [NUM_CH-1:0] pend_v;

    // Registered ready: writes presented while it is still low after reset are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready_q <= 1'b0;
        end else begin
            cfg_ready_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic wr;

        assign wr = bus.cfg_valid && cfg_ready_q && (int'(bus.cfg_ch) == i);

        tick_gen_ch #(
            .CNT_W     (CNT_W),
            .RESET_DIV (DEFAULT_DIV[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .active (bus.en && bus.ch_en[i]),
            .sync   (bus.sync),
            .wr     (wr),
            .wr_div (bus.cfg_div),
            .tick   (tick_v[i]),
            .square (square_v[i]),
            .pend   (pend_v[i])
        );
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.tick        = tick_v;
    assign bus.square      = square_v;
    assign bus.div_pending = pend_v;

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen with channel divisors {5,3,1,0}: vector table plus corner-case sequences.
module tb_tick_gen;
    import tick_gen_pkg::*;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = CNT_W_DEFAULT;
    localparam logic [NUM_CH*CNT_W-1:0] DEF_DIV = {div_t'(0), div_t'(1), div_t'(3), div_t'(5)};

    typedef struct {
        logic       en;
        logic [3:0] ch_en;
        logic       sync;
        logic       cfg_valid;
        logic [1:0] cfg_ch;
        div_t       cfg_div;
        logic [3:0] exp_tick;
        logic [3:0] exp_pend;
        logic [3:0] exp_sq;
    } vec_t;

    vec_t       vecs[$];
    logic [3:0] sync_exp [4] = '{4'b1100, 4'b1101, 4'b1110, 4'b1101};
    int         checks   = 0;
    int         failures = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    tick_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    tick_gen #(
        .INPUT_FREQ  (50_000_000),
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic vec_t make_vec(input logic wr, input logic [1:0] ch, input int div,
                                      input logic [3:0] t, input logic [3:0] p, input logic [3:0] s);
        vec_t v;
        v.en        = 1'b1;
        v.ch_en     = 4'hF;
        v.sync      = 1'b0;
        v.cfg_valid = wr;
        v.cfg_ch    = ch;
        v.cfg_div   = div_t'(div);
        v.exp_tick  = t;
        v.exp_pend  = p;
        v.exp_sq    = s;
        return v;
    endfunction

    task automatic applyStimulus(input logic en, input logic [3:0] ch_en, input logic sync,
                                 input logic valid, input logic [1:0] ch, input div_t div);
        bus.en        = en;
        bus.ch_en     = ch_en;
        bus.sync      = sync;
        bus.cfg_valid = valid;
        bus.cfg_ch    = ch;
        bus.cfg_div   = div;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        logic [3:0] exp_sq;
        logic [3:0] exp_t;

        bus.en        = 1'b0;
        bus.ch_en     = 4'h0;
        bus.sync      = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_ch    = 2'd0;
        bus.cfg_div   = '0;

        // Free run from reset, ch0 rewritten to 8 at cnt=2, ch1 written 4 on a wrap then 6.
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b1100));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b0000));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1110, 4'b0000, 4'b1110));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b0010));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1101, 4'b0000, 4'b1111));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1110, 4'b0000, 4'b0001));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b1101));
        vecs.push_back(make_vec(1'b1, 2'd0, 8, 4'b1100, 4'b0001, 4'b0001));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1110, 4'b0001, 4'b1111));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1101, 4'b0000, 4'b0010));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b1110));
        vecs.push_back(make_vec(1'b1, 2'd1, 4, 4'b1110, 4'b0010, 4'b0000));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0010, 4'b1100));
        vecs.push_back(make_vec(1'b1, 2'd1, 6, 4'b1100, 4'b0010, 4'b0000));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1110, 4'b0000, 4'b1110));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b0010));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b1110));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1101, 4'b0000, 4'b0011));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b1111));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b0011));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1110, 4'b0000, 4'b1101));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b0001));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b1101));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b0001));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1100, 4'b0000, 4'b1101));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1101, 4'b0000, 4'b0000));
        vecs.push_back(make_vec(1'b0, 2'd0, 0, 4'b1110, 4'b0000, 4'b1110));

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset tick", 32'(bus.tick), 32'h0);
        checkOutput("reset square", 32'(bus.square), 32'h0);
        checkOutput("reset pending", 32'(bus.div_pending), 32'h0);
        checkOutput("reset cfg_ready", 32'(bus.cfg_ready), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].ch_en, vecs[i].sync, vecs[i].cfg_valid,
                          vecs[i].cfg_ch, vecs[i].cfg_div);
`ifdef TICK_GEN_SQUARE_EN
            exp_sq = vecs[i].exp_sq;
`else
            exp_sq = 4'b0000;
`endif
            checkOutput($sformatf("vec%0d tick", i + 1), 32'(bus.tick), 32'(vecs[i].exp_tick));
            checkOutput($sformatf("vec%0d pending", i + 1), 32'(bus.div_pending), 32'(vecs[i].exp_pend));
            checkOutput($sformatf("vec%0d square", i + 1), 32'(bus.square), 32'(exp_sq));
        end

        // Reset in mid-count wins over a simultaneous sync and write.
        rst = 1'b1;
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 2'd0, div_t'(9));
        checkOutput("midrst tick", 32'(bus.tick), 32'h0);
        checkOutput("midrst square", 32'(bus.square), 32'h0);
        checkOutput("midrst pending", 32'(bus.div_pending), 32'h0);
        checkOutput("midrst cfg_ready", 32'(bus.cfg_ready), 32'h0);
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 2'd0, div_t'(9));
        checkOutput("midrst2 pending", 32'(bus.div_pending), 32'h0);
        checkOutput("midrst2 cfg_ready", 32'(bus.cfg_ready), 32'h0);
        rst = 1'b0;

        // Write offered while cfg_ready is still low must be dropped.
        applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 2'd0, div_t'(2));
        checkOutput("postrst pending", 32'(bus.div_pending), 32'h0);
        checkOutput("postrst cfg_ready", 32'(bus.cfg_ready), 32'h1);
        checkOutput("postrst tick k1", 32'(bus.tick), 32'hC);
        for (int k = 2; k <= 7; k++) begin
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, div_t'(0));
            exp_t = {2'b11, (k % 3 == 0), (k % 5 == 0)};
            checkOutput($sformatf("postrst tick k%0d", k), 32'(bus.tick), 32'(exp_t));
        end

        // Sync with a same-cycle write of 2 to ch0: direct apply, all channels restart in phase.
        applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 2'd0, div_t'(2));
        checkOutput("sync tick", 32'(bus.tick), 32'h0);
        checkOutput("sync square", 32'(bus.square), 32'h0);
        checkOutput("sync pending", 32'(bus.div_pending), 32'h0);
        for (int j = 1; j <= 4; j++) begin
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, div_t'(0));
            checkOutput($sformatf("sync+%0d tick", j), 32'(bus.tick), 32'(sync_exp[j-1]));
            checkOutput($sformatf("sync+%0d pending", j), 32'(bus.div_pending), 32'h0);
        end

        // ch1 (cnt=1) idled for 7 cycles; a write of 4 during the gap lands while idle.
        for (int g = 1; g <= 7; g++) begin
            applyStimulus(1'b1, 4'b1101, 1'b0, (g == 2), 2'd1, div_t'(4));
            exp_t = {2'b11, 1'b0, (g % 2 == 0)};
            checkOutput($sformatf("gap%0d tick", g), 32'(bus.tick), 32'(exp_t));
            checkOutput($sformatf("gap%0d pending", g), 32'(bus.div_pending), (g == 2) ? 32'h2 : 32'h0);
        end
        for (int r = 1; r <= 3; r++) begin
            applyStimulus(1'b1, 4'hF, 1'b0, 1'b0, 2'd0, div_t'(0));
            exp_t = {2'b11, (r == 3), (r % 2 == 1)};
            checkOutput($sformatf("resume%0d tick", r), 32'(bus.tick), 32'(exp_t));
        end

        for (int z = 1; z <= 4; z++) begin
            applyStimulus(1'b0, 4'hF, 1'b0, 1'b0, 2'd0, div_t'(0));
            checkOutput($sformatf("en_off%0d tick", z), 32'(bus.tick), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
